// File: rtl/piece_mover_if.sv
// Board/piece link: the board FSM supplies the spawn request and settled cells,
// the piece mover returns the four falling cells plus landing/loss events.
interface piece_mover_if;
  localparam int unsigned BOARD_W = 120;
  localparam int unsigned COORD_W = 4;

  logic               gen_flag;
  logic [BOARD_W-1:0] board;
  logic [COORD_W-1:0] x1, y1, x2, y2, x3, y3, x4, y4;
  logic               bottom_flag;
  logic               top_flag;

  modport master (
    input  gen_flag, board,
    output x1, y1, x2, y2, x3, y3, x4, y4, bottom_flag, top_flag
  );

  modport slave (
    output gen_flag, board,
    input  x1, y1, x2, y2, x3, y3, x4, y4, bottom_flag, top_flag
  );
endinterface

// File: rtl/piece_mover.sv
// Falling-tetromino controller: spawn, rotate/shift/gravity with board collision checks.
// Optional hard drop (BtnDrop -> DROP state) is built when HARD_DROP_EN is defined.
module piece_mover #(
  parameter int unsigned SPAWN_COL = 3,
  parameter logic [7:0]  SEED      = 8'h5A
) (
  input  logic          Clk,
  input  logic          Resetn,
  input  logic          tick,
  input  logic          BtnL,
  input  logic          BtnR,
  input  logic          BtnRot,
  input  logic          BtnDrop,
  piece_mover_if.master bus,
  output logic [2:0]    piece_state
);

  localparam int unsigned ROWS    = 12;
  localparam int unsigned COLS    = 10;
  localparam int unsigned CW      = 4;
  localparam int unsigned CELLS_W = 8 * CW;
  localparam int unsigned BOARD_W = ROWS * COLS;
  localparam int unsigned IDX_W   = 7;
  localparam logic [CW-1:0] MAX_ROW = CW'(ROWS - 1);
  localparam logic [CW-1:0] MAX_COL = CW'(COLS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SPAWN = 3'd1,
    CHECK = 3'd2,
    FALL  = 3'd3,
    LAND  = 3'd4,
    LOST  = 3'd5
`ifdef HARD_DROP_EN
    , DROP = 3'd6
`endif
  } state_e;

  // Offsets packed MSB-first as {dy0,dx0,dy1,dx1,dy2,dx2,dy3,dx3}, row-major, normalised.
  function automatic logic [15:0] shape(input logic [2:0] typ, input logic [1:0] rot);
    logic [15:0] s;
    case (typ)
      3'd0: s = rot[0] ? 16'b00_00_01_00_10_00_11_00 : 16'b00_00_00_01_00_10_00_11;
      3'd1: s = 16'b00_00_00_01_01_00_01_01;
      3'd2: case (rot)
              2'd0:    s = 16'b00_01_01_00_01_01_01_10;
              2'd1:    s = 16'b00_00_01_00_01_01_10_00;
              2'd2:    s = 16'b00_00_00_01_00_10_01_01;
              default: s = 16'b00_01_01_00_01_01_10_01;
            endcase
      3'd3: s = rot[0] ? 16'b00_00_01_00_01_01_10_01 : 16'b00_01_00_10_01_00_01_01;
      3'd4: s = rot[0] ? 16'b00_01_01_00_01_01_10_00 : 16'b00_00_00_01_01_01_01_10;
      3'd5: case (rot)
              2'd0:    s = 16'b00_00_01_00_01_01_01_10;
              2'd1:    s = 16'b00_00_00_01_01_00_10_00;
              2'd2:    s = 16'b00_00_00_01_00_10_01_10;
              default: s = 16'b00_01_01_01_10_00_10_01;
            endcase
      3'd6: case (rot)
              2'd0:    s = 16'b00_10_01_00_01_01_01_10;
              2'd1:    s = 16'b00_00_01_00_10_00_10_01;
              2'd2:    s = 16'b00_00_00_01_00_10_01_00;
              default: s = 16'b00_00_00_01_01_01_10_01;
            endcase
      default: s = 16'b00_00_00_01_00_10_00_11;
    endcase
    return s;
  endfunction

  // Absolute cells, cell 0 in the top byte as {row, col}.
  function automatic logic [CELLS_W-1:0] place(input logic [CW-1:0] row, input logic [CW-1:0] col,
                                               input logic [2:0] typ, input logic [1:0] rot);
    logic [15:0]        s;
    logic [CELLS_W-1:0] c;
    s = shape(typ, rot);
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[CELLS_W-1-8*k -: 4] = row + {2'b00, s[15-4*k -: 2]};
      c[CELLS_W-5-8*k -: 4] = col + {2'b00, s[13-4*k -: 2]};
    end
    return c;
  endfunction

  function automatic logic legal(input logic [CELLS_W-1:0] c, input logic [BOARD_W-1:0] brd);
    logic             ok;
    logic [CW-1:0]    r;
    logic [CW-1:0]    q;
    logic [IDX_W-1:0] idx;
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      r = c[CELLS_W-1-8*k -: 4];
      q = c[CELLS_W-5-8*k -: 4];
      if (r > MAX_ROW || q > MAX_COL) begin
        ok = 1'b0;
      end else begin
        idx = IDX_W'(r) * IDX_W'(COLS) + IDX_W'(q);
        if (brd[idx]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  state_e             state_q, state_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic [CW-1:0]      row_q, row_d, col_q, col_d;
  logic [2:0]         typ_q, typ_d;
  logic [1:0]         rot_q, rot_d;
  logic               pend_q, pend_d;
  logic [CELLS_W-1:0] cells_q, cells_d;
  logic               bottom_q, bottom_d;
  logic               top_q, top_d;

  logic [2:0] type_c;
  logic       commit_c;
  logic       cur_ok_c, rot_ok_c, left_ok_c, right_ok_c, down_ok_c;

  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign type_c = (lfsr_q[2:0] == 3'd7) ? 3'd0 : lfsr_q[2:0];

  assign cur_ok_c   = legal(place(row_q, col_q, typ_q, rot_q), bus.board);
  assign rot_ok_c   = legal(place(row_q, col_q, typ_q, rot_q + 2'd1), bus.board);
  assign left_ok_c  = (col_q != '0) && legal(place(row_q, col_q - 4'd1, typ_q, rot_q), bus.board);
  assign right_ok_c = legal(place(row_q, col_q + 4'd1, typ_q, rot_q), bus.board);
  assign down_ok_c  = legal(place(row_q + 4'd1, col_q, typ_q, rot_q), bus.board);

`ifndef HARD_DROP_EN
  logic unused_drop_c;
  assign unused_drop_c = BtnDrop;
`endif

  // Next-state and datapath updates; cells_q only reloads when the placement changes.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    typ_d    = typ_q;
    rot_d    = rot_q;
    pend_d   = pend_q;
    bottom_d = 1'b0;
    top_d    = top_q;
    commit_c = 1'b0;
    cells_d  = cells_q;

    if (tick && state_q != IDLE) pend_d = 1'b1;

    case (state_q)
      IDLE, LOST: begin
        if (bus.gen_flag) begin
          typ_d    = type_c;
          rot_d    = 2'd0;
          row_d    = '0;
          col_d    = CW'(SPAWN_COL);
          top_d    = 1'b0;
          commit_c = 1'b1;
          state_d  = SPAWN;
        end
      end
      SPAWN, CHECK: begin
        if (cur_ok_c) begin
          state_d = FALL;
        end else begin
          state_d = LOST;
          top_d   = 1'b1;
        end
      end
      FALL: begin
`ifdef HARD_DROP_EN
        if (BtnDrop) begin
          state_d = DROP;
        end else
`endif
        if (BtnRot) begin
          if (rot_ok_c) begin
            rot_d    = rot_q + 2'd1;
            commit_c = 1'b1;
          end
        end else if (BtnL) begin
          if (left_ok_c) begin
            col_d    = col_q - 4'd1;
            commit_c = 1'b1;
          end
        end else if (BtnR) begin
          if (right_ok_c) begin
            col_d    = col_q + 4'd1;
            commit_c = 1'b1;
          end
        end else if (pend_q) begin
          pend_d = tick;
          if (down_ok_c) begin
            row_d    = row_q + 4'd1;
            commit_c = 1'b1;
          end else begin
            state_d  = LAND;
            bottom_d = 1'b1;
          end
        end
      end
`ifdef HARD_DROP_EN
      DROP: begin
        if (down_ok_c) begin
          row_d    = row_q + 4'd1;
          commit_c = 1'b1;
        end else begin
          state_d  = LAND;
          bottom_d = 1'b1;
        end
      end
`endif
      LAND: begin
        state_d = IDLE;
        pend_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (commit_c) cells_d = place(row_d, col_d, typ_d, rot_d);
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED;
      row_q    <= '0;
      col_q    <= '0;
      typ_q    <= '0;
      rot_q    <= '0;
      pend_q   <= 1'b0;
      cells_q  <= '0;
      bottom_q <= 1'b0;
      top_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      row_q    <= row_d;
      col_q    <= col_d;
      typ_q    <= typ_d;
      rot_q    <= rot_d;
      pend_q   <= pend_d;
      cells_q  <= cells_d;
      bottom_q <= bottom_d;
      top_q    <= top_d;
    end
  end

  assign bus.x1 = cells_q[31:28];
  assign bus.y1 = cells_q[27:24];
  assign bus.x2 = cells_q[23:20];
  assign bus.y2 = cells_q[19:16];
  assign bus.x3 = cells_q[15:12];
  assign bus.y3 = cells_q[11:8];
  assign bus.x4 = cells_q[7:4];
  assign bus.y4 = cells_q[3:0];
  assign bus.bottom_flag = bottom_q;
  assign bus.top_flag    = top_q;
  assign piece_state     = state_q;

endmodule
